alu_control_seq: RTL and testbench
==================================

# alu_control_seq

Registered, handshaked ALU control unit for the 16-bit team-B datapath; successor to the combinational ALU decoder. Decodes `op`/`func` into an ALU operation code and, optionally, expands variable shifts into a sequence of shift-by-one micro-ops for the single-bit shifter. Sits between instruction decode and the ALU, using a valid/ready handshake on both sides so the decoder can stall the fetch stage during multi-cycle shifts.

## Interface
- `OP_W`, default 4: opcode width, at least 4.
- `FUNC_W`, default 4: function-field width, at least 4.
- `ALUOP_W`, default 4: ALU operation code width, at least 4; table codes are zero-extended.
- `SHAMT_W`, default 4: shift-amount width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: the block accepts the instruction on this cycle.
- `op` in `OP_W`: opcode.
- `func` in `FUNC_W`: function field, used only when `op`==0.
- `shamt` in `SHAMT_W`: shift amount for sll/srl.
- `out_valid` out 1: a micro-op is presented to the ALU.
- `out_ready` in 1: the ALU/datapath consumes the micro-op.
- `ALUop` out `ALUOP_W`: ALU operation code of the current micro-op.
- `shamt_o` out `SHAMT_W`: shift amount for the current micro-op.
- `last` out 1: the current micro-op is the final one of its instruction.
- `illegal` out 1: the instruction is an unused or out-of-range encoding.
- `busy` out 1: a multi-micro-op instruction is in progress (`cnt`>1).

## Operation
- R-type (`op`==0), `func` to ALUop:
  - 0000 add→0000; 0001 and→0011; 0010 or→0001; 0011 xor→0010; 0100 nor→0100.
  - 0110 copy→0000; 0111 jr→0000; 1000 nand→1000; 1001 slt→1111; 1010 sub→0111.
  - 0101 and 1011–1111→0000 with `illegal`=1.
- Other opcodes, `op` to ALUop:
  - 0001 addi→0000; 0010 beq and 0011 bne→0111; 0100 j→0000; 0101 lw and 0110 sw→0000.
  - 1000 li→0000; 1001 ori→0001; 1010 andi→0011; 1011 nori→0100.
  - 1100 sll→0101; 1101 srl→0110; 1110 beqz and 1111 bnez→1110.
  - 0111→0000 with `illegal`=1.
- Any `op` or `func` value above 15 (wide parameters): ALUop 0, `illegal`=1.
- Internal state:
  - Output register: `ALUop`, `shamt_o`, `illegal`, `out_valid`.
  - Counter `cnt`, `SHAMT_W`+1 bits: micro-ops remaining, including the one currently presented.
- FSM states:
  - IDLE: `out_valid`=0.
  - EMIT: `out_valid`=1, `cnt`≥1.
- `in_ready` = !`out_valid` || (`out_ready` && `cnt`==1). This is combinational, with no dependency on `in_valid`.
- Accept when `in_valid`&&`in_ready`:
  - Load the output register.
  - Load `cnt` (1 for non-shifts).
  - Go to EMIT.
- Advance when `out_valid`&&`out_ready`:
  - If `cnt`>1: decrement `cnt` and hold ALUop.
  - If `cnt`==1 with a simultaneous accept: load the new instruction, giving back-to-back issue.
  - If `cnt`==1 without an accept: go to IDLE.
- `last` = `out_valid` && `cnt`==1.
- `busy` = `cnt`>1.
- When `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- `illegal` instructions are still issued as one micro-op; trapping is the consumer's job.

## Timing
- Reset: on the first rising edge with `reset`=1, all of the following clear and the FSM enters IDLE.
  - `out_valid`, `last`, `busy` and `illegal` go to 0.
  - `ALUop` and `shamt_o` go to 0; `cnt` goes to 0.
- `in_ready` is 1 on the first cycle after reset.
- Reset mid-shift abandons the remaining micro-ops. Reset has priority over accept and advance.
- Latency: accept on edge N → `out_valid`=1 after edge N, visible in cycle N+1.
- Throughput: one single-micro-op instruction per cycle when `out_ready`=1.
- A shift of amount k holds `in_ready`=0 for k−1 consumed cycles.

## Configuration
- `ALU_CTRL_MULTISHIFT_EN` defined, for sll/srl:
  - `cnt` loads `shamt`, and `shamt_o`=1 on every micro-op.
  - `shamt`==0 loads one micro-op with ALUop 0000, `shamt_o`=0 and `last`=1 (pass-through).
- `ALU_CTRL_MULTISHIFT_EN` undefined:
  - Every instruction is one micro-op; `cnt` is always 1 and `busy` is constant 0.
  - sll/srl issue ALUop 0101/0110 with `shamt_o`=`shamt` for a barrel shifter.

## Test plan
- Reset, then sweep all 16 `func` with `op`=0 and all 15 nonzero `op`, with `out_ready`=1 → each ALUop/`illegal` matches the table one cycle after accept, and `in_ready` stays 1 throughout.
- Back-to-back add, sub, slt with `out_ready`=1 → ALUop 0000, 0111, 1111 on consecutive cycles, each with `last`=1.
- With the macro defined: sll `shamt`=3, `out_ready`=1 → three cycles of ALUop 0101 and `shamt_o`=1; `last` only on the third; `in_ready`=0 for two cycles; `busy` is 1,1,0.
- Backpressure: srl `shamt`=2 with `out_ready` low for 4 cycles → outputs frozen with `cnt`=2; after `out_ready` rises, exactly two micro-ops issue.
- Reset asserted on the second micro-op of sll `shamt`=5 → next cycle `out_valid`=0, `ALUop`=0, `busy`=0, `in_ready`=1.
- With the macro undefined: sll `shamt`=7 → a single micro-op with ALUop 0101, `shamt_o`=7 and `last`=1; `shamt`=0 yields ALUop 0101, `shamt_o`=0.

Source files
------------

// File: rtl/alu_control_seq.sv
// Registered ALU control unit with valid/ready handshake on both sides.
// Optional ALU_CTRL_MULTISHIFT_EN expands sll/srl into shift-by-one micro-ops.
module alu_control_seq #(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 4,
  parameter int ALUOP_W = 4,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic               last,
  output logic               illegal,
  output logic               busy
);

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [ALUOP_W-1:0] r_aluop;
  logic [SHAMT_W-1:0] r_shamt_o;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_cnt;

  logic [31:0]        w_op_ext, w_func_ext;
  logic [3:0]         w_code;
  logic               w_ill, w_shift;
  logic [ALUOP_W-1:0] w_ld_aluop;
  logic [SHAMT_W-1:0] w_ld_shamt;
  logic [CNT_W-1:0]   w_ld_cnt;
  logic               w_out_valid, w_cnt_one, w_accept, w_advance;

  // Zero-extend so out-of-range encodings on wide parameters are detectable.
  assign w_op_ext   = 32'(op);
  assign w_func_ext = 32'(func);

  always_comb begin
    w_code  = '0;
    w_ill   = 1'b0;
    w_shift = 1'b0;
    if (|w_op_ext[31:4]) begin
      w_ill = 1'b1;
    end else if (w_op_ext[3:0] == 4'h0) begin
      if (|w_func_ext[31:4]) begin
        w_ill = 1'b1;
      end else begin
        case (w_func_ext[3:0])
          4'h0:       w_code = 4'b0000;
          4'h1:       w_code = 4'b0011;
          4'h2:       w_code = 4'b0001;
          4'h3:       w_code = 4'b0010;
          4'h4:       w_code = 4'b0100;
          4'h6, 4'h7: w_code = 4'b0000;
          4'h8:       w_code = 4'b1000;
          4'h9:       w_code = 4'b1111;
          4'hA:       w_code = 4'b0111;
          default:    w_ill  = 1'b1;
        endcase
      end
    end else begin
      case (w_op_ext[3:0])
        4'h1, 4'h4, 4'h5, 4'h6, 4'h8: w_code = 4'b0000;
        4'h2, 4'h3: w_code = 4'b0111;
        4'h9:       w_code = 4'b0001;
        4'hA:       w_code = 4'b0011;
        4'hB:       w_code = 4'b0100;
        4'hC: begin w_code = 4'b0101; w_shift = 1'b1; end
        4'hD: begin w_code = 4'b0110; w_shift = 1'b1; end
        4'hE, 4'hF: w_code = 4'b1110;
        default:    w_ill  = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_ld_aluop = ALUOP_W'(w_code);
    w_ld_shamt = '0;
    w_ld_cnt   = CNT_W'(1);
    if (w_shift) begin
`ifdef ALU_CTRL_MULTISHIFT_EN
      if (shamt == '0) begin
        w_ld_aluop = '0;
      end else begin
        w_ld_shamt = SHAMT_W'(1);
        w_ld_cnt   = {1'b0, shamt};
      end
`else
      w_ld_shamt = shamt;
`endif
    end
  end

  assign w_out_valid = (r_state == EMIT);
  assign w_cnt_one   = (r_cnt == CNT_W'(1));
  assign in_ready    = !w_out_valid || (out_ready && w_cnt_one);
  assign w_accept    = in_valid && in_ready;
  assign w_advance   = w_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)                    w_state_nxt = EMIT;
    else if (w_advance && w_cnt_one) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aluop   <= '0;
      r_shamt_o <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_aluop   <= w_ld_aluop;
      r_shamt_o <= w_ld_shamt;
      r_illegal <= w_ill;
      r_cnt     <= w_ld_cnt;
    end else if (w_advance) begin
      if (w_cnt_one) r_cnt <= '0;
      else           r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign out_valid = w_out_valid;
  assign ALUop     = r_aluop;
  assign shamt_o   = r_shamt_o;
  assign illegal   = r_illegal;
  assign last      = w_out_valid && w_cnt_one;
`ifdef ALU_CTRL_MULTISHIFT_EN
  assign busy      = (r_cnt > CNT_W'(1));
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq; follows ALU_CTRL_MULTISHIFT_EN if defined.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op, func, shamt, ALUop, shamt_o;
  logic       last, illegal, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_uops;

  int func_exp [16] = '{0, 3, 1, 2, 4, 0, 0, 0, 8, 15, 7, 0, 0, 0, 0, 0};
  int func_ill [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int op_exp   [16] = '{0, 0, 7, 7, 0, 0, 0, 0, 0, 1, 3, 4, 5, 6, 14, 14};
  int op_ill   [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  alu_control_seq #(.OP_W(4), .FUNC_W(4), .ALUOP_W(4), .SHAMT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .func(func), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .ALUop(ALUop), .shamt_o(shamt_o), .last(last),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    op = 4'd0; func = 4'd0; shamt = 4'd0;
    step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_last", 32'(last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_aluop", 32'(ALUop), 0);
    check("rst_shamt_o", 32'(shamt_o), 0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // R-type sweep, one instruction per cycle
    for (int i = 0; i < 16; i++) begin
      op = 4'd0; func = 4'(i); shamt = 4'd1; in_valid = 1'b1;
      #1;
      check($sformatf("func%0d_in_ready", i), 32'(in_ready), 1);
      step();
      check($sformatf("func%0d_aluop", i), 32'(ALUop), 32'(func_exp[i]));
      check($sformatf("func%0d_illegal", i), 32'(illegal), 32'(func_ill[i]));
      check($sformatf("func%0d_last", i), 32'(last), 1);
    end
    for (int i = 1; i < 16; i++) begin
      op = 4'(i); func = 4'd0; shamt = 4'd1; in_valid = 1'b1;
      #1;
      check($sformatf("op%0d_in_ready", i), 32'(in_ready), 1);
      step();
      check($sformatf("op%0d_aluop", i), 32'(ALUop), 32'(op_exp[i]));
      check($sformatf("op%0d_illegal", i), 32'(illegal), 32'(op_ill[i]));
      check($sformatf("op%0d_out_valid", i), 32'(out_valid), 1);
    end

    // back-to-back add, sub, slt
    op = 4'd0; func = 4'd0; step();
    check("b2b_add", 32'(ALUop), 0);
    check("b2b_add_last", 32'(last), 1);
    func = 4'd10; step();
    check("b2b_sub", 32'(ALUop), 7);
    check("b2b_sub_last", 32'(last), 1);
    func = 4'd9; step();
    check("b2b_slt", 32'(ALUop), 15);
    check("b2b_slt_last", 32'(last), 1);
    in_valid = 1'b0; step();
    check("drain_out_valid", 32'(out_valid), 0);

`ifdef ALU_CTRL_MULTISHIFT_EN
    op = 4'd12; shamt = 4'd3; in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sll3_%0d_aluop", k), 32'(ALUop), 5);
      check($sformatf("sll3_%0d_shamt_o", k), 32'(shamt_o), 1);
      check($sformatf("sll3_%0d_last", k), 32'(last), (k == 2) ? 1 : 0);
      check($sformatf("sll3_%0d_busy", k), 32'(busy), (k == 2) ? 0 : 1);
      check($sformatf("sll3_%0d_in_ready", k), 32'(in_ready), (k == 2) ? 1 : 0);
      step();
    end
    check("sll3_done", 32'(out_valid), 0);
    op = 4'd12; shamt = 4'd0; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("sll0_aluop", 32'(ALUop), 0);
    check("sll0_shamt_o", 32'(shamt_o), 0);
    check("sll0_last", 32'(last), 1);
    step();
`else
    op = 4'd12; shamt = 4'd7; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("sll7_aluop", 32'(ALUop), 5);
    check("sll7_shamt_o", 32'(shamt_o), 7);
    check("sll7_last", 32'(last), 1);
    check("sll7_busy", 32'(busy), 0);
    check("sll7_in_ready", 32'(in_ready), 1);
    step();
    check("sll7_done", 32'(out_valid), 0);
    op = 4'd12; shamt = 4'd0; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("sll0_aluop", 32'(ALUop), 5);
    check("sll0_shamt_o", 32'(shamt_o), 0);
    check("sll0_last", 32'(last), 1);
    step();
`endif

    // srl 2 under backpressure
    out_ready = 1'b0; op = 4'd13; shamt = 4'd2; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 1);
      check($sformatf("bp%0d_aluop", k), 32'(ALUop), 6);
`ifdef ALU_CTRL_MULTISHIFT_EN
      check($sformatf("bp%0d_shamt_o", k), 32'(shamt_o), 1);
      check($sformatf("bp%0d_busy", k), 32'(busy), 1);
      check($sformatf("bp%0d_last", k), 32'(last), 0);
`else
      check($sformatf("bp%0d_shamt_o", k), 32'(shamt_o), 2);
      check($sformatf("bp%0d_last", k), 32'(last), 1);
`endif
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    n_uops = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid && out_ready) n_uops++;
      step();
    end
`ifdef ALU_CTRL_MULTISHIFT_EN
    check("bp_uop_count", 32'(n_uops), 2);
`else
    check("bp_uop_count", 32'(n_uops), 1);
`endif

    // reset mid-instruction, with a competing accept
    op = 4'd12; shamt = 4'd5; in_valid = 1'b1; step(); in_valid = 1'b0;
`ifdef ALU_CTRL_MULTISHIFT_EN
    step();
    check("rmid_busy_before", 32'(busy), 1);
`endif
    check("rmid_valid_before", 32'(out_valid), 1);
    out_ready = 1'b0; reset = 1'b1; in_valid = 1'b1; op = 4'd2;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rmid_out_valid", 32'(out_valid), 0);
    check("rmid_aluop", 32'(ALUop), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_shamt_o", 32'(shamt_o), 0);
    check("rmid_in_ready", 32'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
